// File: rtl/midway_vga_scan_timing.sv
// Raster timing generator for the Midway 8080 memory adapter: scan addresses out, RGB back in,
// sync-aligned VGA pins. Optional colour-bar source under MIDWAY_SCAN_TEST_PATTERN_EN.
module midway_vga_scan_timing #(
  parameter int unsigned H_ACTIVE     = 640,
  parameter int unsigned H_FP         = 16,
  parameter int unsigned H_SYNC       = 96,
  parameter int unsigned H_BP         = 48,
  parameter int unsigned V_ACTIVE     = 480,
  parameter int unsigned V_FP         = 10,
  parameter int unsigned V_SYNC       = 2,
  parameter int unsigned V_BP         = 33,
  parameter int unsigned PIPE_LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pix_ce,
  output logic [9:0]  vga_x_address,
  output logic [8:0]  vga_y_address,
  input  logic [23:0] rgb_in,
`ifdef MIDWAY_SCAN_TEST_PATTERN_EN
  input  logic        pattern_sel,
`endif
  output logic [7:0]  vga_r,
  output logic [7:0]  vga_g,
  output logic [7:0]  vga_b,
  output logic        vga_hs_n,
  output logic        vga_vs_n,
  output logic        vga_blank_n,
  output logic        frame_start
);

  localparam logic [9:0] HActive  = 10'(H_ACTIVE);
  localparam logic [9:0] HLast    = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] HsStart  = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HsEnd    = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VActive  = 10'(V_ACTIVE);
  localparam logic [9:0] VLast    = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [9:0] VsStart  = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VsEnd    = 10'(V_ACTIVE + V_FP + V_SYNC);

  // Delay-line word: {bar[2:0], active, hs, vs} with the pattern, {active, hs, vs} without.
`ifdef MIDWAY_SCAN_TEST_PATTERN_EN
  localparam int unsigned PW = 6;
`else
  localparam int unsigned PW = 3;
`endif
  localparam logic [PW-1:0] PipeIdle = PW'(3'b011);

  logic [9:0]    h_count_q, h_count_d;
  logic [9:0]    v_count_q, v_count_d;
  logic          h_last, v_last;
  logic          h_act, v_act;
  logic          active_raw, hs_raw, vs_raw;
  logic [PW-1:0] pipe_in;
  logic [PW-1:0] pipe_q [PIPE_LATENCY];
  logic [PW-1:0] pipe_tail;
  logic [23:0]   rgb_src;

  always_comb begin
    h_last    = (h_count_q == HLast);
    v_last    = (v_count_q == VLast);
    h_count_d = h_count_q;
    v_count_d = v_count_q;
    if (pix_ce) begin
      if (h_last) begin
        h_count_d = '0;
        v_count_d = v_last ? '0 : v_count_q + 10'd1;
      end else begin
        h_count_d = h_count_q + 10'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      h_count_q <= '0;
      v_count_q <= '0;
    end else begin
      h_count_q <= h_count_d;
      v_count_q <= v_count_d;
    end
  end

  always_comb begin
    h_act         = (h_count_q < HActive);
    v_act         = (v_count_q < VActive);
    vga_x_address = h_act ? h_count_q : '0;
    vga_y_address = v_act ? v_count_q[8:0] : '0;
    active_raw    = h_act && v_act;
    hs_raw        = !((h_count_q >= HsStart) && (h_count_q < HsEnd));
    vs_raw        = !((v_count_q >= VsStart) && (v_count_q < VsEnd));
    frame_start   = pix_ce && h_last && v_last;
`ifdef MIDWAY_SCAN_TEST_PATTERN_EN
    pipe_in       = {vga_x_address[9:7], active_raw, hs_raw, vs_raw};
`else
    pipe_in       = {active_raw, hs_raw, vs_raw};
`endif
  end

  // Stage count matches the adapter's read latency so the tail lines up with rgb_in.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(PIPE_LATENCY); i++) pipe_q[i] <= PipeIdle;
    end else if (pix_ce) begin
      pipe_q[0] <= pipe_in;
      for (int i = 1; i < int'(PIPE_LATENCY); i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  assign pipe_tail = pipe_q[PIPE_LATENCY-1];

  always_comb begin
    rgb_src = rgb_in;
`ifdef MIDWAY_SCAN_TEST_PATTERN_EN
    if (pattern_sel) begin
      rgb_src = {{8{pipe_tail[5]}}, {8{pipe_tail[4]}}, {8{pipe_tail[3]}}};
    end
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vga_r       <= '0;
      vga_g       <= '0;
      vga_b       <= '0;
      vga_hs_n    <= 1'b1;
      vga_vs_n    <= 1'b1;
      vga_blank_n <= 1'b0;
    end else if (pix_ce) begin
      vga_r       <= pipe_tail[2] ? rgb_src[23:16] : 8'h00;
      vga_g       <= pipe_tail[2] ? rgb_src[15:8]  : 8'h00;
      vga_b       <= pipe_tail[2] ? rgb_src[7:0]   : 8'h00;
      vga_blank_n <= pipe_tail[2];
      vga_hs_n    <= pipe_tail[1];
      vga_vs_n    <= pipe_tail[0];
    end
  end

endmodule

// File: tb/tb_midway_vga_scan_timing.sv
// Bench for midway_vga_scan_timing: latency-1 and latency-3 instances at full VGA geometry plus a
// shrunken-geometry instance for frame-level timing.
module tb_midway_vga_scan_timing;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic pix_ce = 1'b0;
`ifdef MIDWAY_SCAN_TEST_PATTERN_EN
  logic pattern_sel = 1'b0;
`endif
  always #5 clk = ~clk;

  logic [9:0]  x1, x3, xs;
  logic [8:0]  y1, y3, ys;
  logic [7:0]  r1, g1, b1, r3, g3, b3, rs, gs, bs;
  logic        hs1, vs1, bl1, fs1, hs3, vs3, bl3, fs3, hss, vss, bls, fss;
  logic [23:0] rgb1, rgb3, rgbs;

  // Memory models: return {x, y, A5} PIPE_LATENCY ticks after the address.
  logic [23:0] m1_q;
  logic [23:0] m3_q [3];
  logic [23:0] ms_q [2];
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m1_q <= '0;
      for (int i = 0; i < 3; i++) m3_q[i] <= '0;
      for (int i = 0; i < 2; i++) ms_q[i] <= '0;
    end else if (pix_ce) begin
      m1_q    <= {x1[7:0], y1[7:0], 8'hA5};
      m3_q[0] <= {x3[7:0], y3[7:0], 8'hA5};
      m3_q[1] <= m3_q[0];
      m3_q[2] <= m3_q[1];
      ms_q[0] <= {xs[7:0], ys[7:0], 8'hA5};
      ms_q[1] <= ms_q[0];
    end
  end
  assign rgb1 = m1_q;
  assign rgb3 = m3_q[2];
  assign rgbs = ms_q[1];

  midway_vga_scan_timing #(.PIPE_LATENCY(1)) u_d1 (
    .clk(clk), .reset(reset), .pix_ce(pix_ce), .vga_x_address(x1), .vga_y_address(y1),
`ifdef MIDWAY_SCAN_TEST_PATTERN_EN
    .pattern_sel(pattern_sel),
`endif
    .rgb_in(rgb1), .vga_r(r1), .vga_g(g1), .vga_b(b1), .vga_hs_n(hs1), .vga_vs_n(vs1),
    .vga_blank_n(bl1), .frame_start(fs1)
  );

  midway_vga_scan_timing #(.PIPE_LATENCY(3)) u_d3 (
    .clk(clk), .reset(reset), .pix_ce(pix_ce), .vga_x_address(x3), .vga_y_address(y3),
`ifdef MIDWAY_SCAN_TEST_PATTERN_EN
    .pattern_sel(pattern_sel),
`endif
    .rgb_in(rgb3), .vga_r(r3), .vga_g(g3), .vga_b(b3), .vga_hs_n(hs3), .vga_vs_n(vs3),
    .vga_blank_n(bl3), .frame_start(fs3)
  );

  // 16 x 13 raster, 208 ticks per frame.
  midway_vga_scan_timing #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(6), .V_FP(2), .V_SYNC(2), .V_BP(3), .PIPE_LATENCY(2)
  ) u_ds (
    .clk(clk), .reset(reset), .pix_ce(pix_ce), .vga_x_address(xs), .vga_y_address(ys),
`ifdef MIDWAY_SCAN_TEST_PATTERN_EN
    .pattern_sel(pattern_sel),
`endif
    .rgb_in(rgbs), .vga_r(rs), .vga_g(gs), .vga_b(bs), .vga_hs_n(hss), .vga_vs_n(vss),
    .vga_blank_n(bls), .frame_start(fss)
  );

  wire [26:0] o1_act = {hs1, vs1, bl1, r1, g1, b1};
  wire [26:0] o3_act = {hs3, vs3, bl3, r3, g3, b3};

  int checks = 0;
  int failures = 0;
  int ticks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [26:0] o(input logic hs, input logic vs, input logic bl,
                                    input logic [23:0] rgb);
    return {hs, vs, bl, rgb};
  endfunction

  task automatic step_to(input int k);
    if (k > ticks) begin
      repeat (k - ticks) @(posedge clk);
      ticks = k;
    end
    @(negedge clk);
  endtask

  typedef struct {
    int          k;
    logic [9:0]  x;
    logic [8:0]  y;
    logic [26:0] o1;
    logic [26:0] o3;
  } vec_t;

  // Window statistics, gathered per sample clock.
  int w_x_bad, w_hs_low, w_bl, w_hs_fall, w_svs, w_shs, w_sbl, w_shs_gap, w_shs_last;
  int w_fs_cnt, w_fs_first, w_fs_last, w_fs_gap, w_fs_wide;

  task automatic window(input int n, input bit alt);
    int   t;
    logic hs_prev, shs_prev, fs_prev;
    logic [9:0] exp_x;
    w_x_bad = 0; w_hs_low = 0; w_bl = 0; w_hs_fall = -1; w_svs = 0; w_shs = 0; w_sbl = 0;
    w_shs_gap = -1; w_shs_last = -1; w_fs_cnt = 0; w_fs_first = -1; w_fs_last = -1;
    w_fs_gap = -1; w_fs_wide = 0;
    t = 0; hs_prev = 1'b1; shs_prev = 1'b1; fs_prev = 1'b0;
    reset = 1'b0;
    pix_ce = 1'b1;
    for (int i = 1; i <= n; i++) begin
      @(negedge clk);
      if (pix_ce) t++;
      exp_x = ((t % 16) < 8) ? 10'(t % 16) : 10'd0;
      if (xs !== exp_x) w_x_bad++;
      if (!hs1) w_hs_low++;
      if (bl1) w_bl++;
      if (hs_prev && !hs1 && w_hs_fall < 0) w_hs_fall = i;
      hs_prev = hs1;
      if (!vss) w_svs++;
      if (!hss) w_shs++;
      if (bls) w_sbl++;
      if (shs_prev && !hss) begin
        if (w_shs_last >= 0) w_shs_gap = i - w_shs_last;
        w_shs_last = i;
      end
      shs_prev = hss;
      pix_ce = alt ? (((i + 1) % 2) == 1) : 1'b1;
      #1;
      if (fss) begin
        w_fs_cnt++;
        if (w_fs_last >= 0) w_fs_gap = i - w_fs_last;
        if (w_fs_first < 0) w_fs_first = i;
        w_fs_last = i;
      end
      if (fss && fs_prev) w_fs_wide++;
      fs_prev = fss;
    end
  endtask

  vec_t tbl[$];

  initial begin
    logic [26:0] blk, hsl;
    blk = o(1'b1, 1'b1, 1'b0, 24'h0);
    hsl = o(1'b0, 1'b1, 1'b0, 24'h0);
    tbl.push_back('{0,    10'd0,   9'd0, blk, blk});
    tbl.push_back('{1,    10'd1,   9'd0, blk, blk});
    tbl.push_back('{2,    10'd2,   9'd0, o(1, 1, 1, 24'h0000A5), blk});
    tbl.push_back('{4,    10'd4,   9'd0, o(1, 1, 1, 24'h0200A5), o(1, 1, 1, 24'h0000A5)});
    tbl.push_back('{641,  10'd0,   9'd0, o(1, 1, 1, 24'h7F00A5), o(1, 1, 1, 24'h7D00A5)});
    tbl.push_back('{642,  10'd0,   9'd0, blk, o(1, 1, 1, 24'h7E00A5)});
    tbl.push_back('{657,  10'd0,   9'd0, blk, blk});
    tbl.push_back('{658,  10'd0,   9'd0, hsl, blk});
    tbl.push_back('{660,  10'd0,   9'd0, hsl, hsl});
    tbl.push_back('{753,  10'd0,   9'd0, hsl, hsl});
    tbl.push_back('{754,  10'd0,   9'd0, blk, hsl});
    tbl.push_back('{756,  10'd0,   9'd0, blk, blk});
    tbl.push_back('{802,  10'd2,   9'd1, o(1, 1, 1, 24'h0001A5), blk});
    tbl.push_back('{1458, 10'd0,   9'd1, hsl, blk});
    tbl.push_back('{5607, 10'd7,   9'd7, o(1, 1, 1, 24'h0507A5), o(1, 1, 1, 24'h0307A5)});
    tbl.push_back('{5609, 10'd9,   9'd7, o(1, 1, 1, 24'h0707A5), o(1, 1, 1, 24'h0507A5)});
    tbl.push_back('{5900, 10'd300, 9'd7, o(1, 1, 1, 24'h2A07A5), o(1, 1, 1, 24'h2807A5)});

    // Reset values, before any clock edge.
    #1 reset = 1'b1;
    #1;
    chk("rst_x", 32'(x1), 32'd0);
    chk("rst_y", 32'(y1), 32'd0);
    chk("rst_out1", 32'(o1_act), 32'(blk));
    chk("rst_out3", 32'(o3_act), 32'(blk));
    chk("rst_fs", 32'(fs1), 32'd0);

    pix_ce = 1'b1;
    @(posedge clk);
    #2 reset = 1'b0;
    ticks = 0;
    foreach (tbl[i]) begin
      step_to(tbl[i].k);
      chk($sformatf("x@%0d", tbl[i].k), 32'(x1), 32'(tbl[i].x));
      chk($sformatf("y@%0d", tbl[i].k), 32'(y1), 32'(tbl[i].y));
      chk($sformatf("out1@%0d", tbl[i].k), 32'(o1_act), 32'(tbl[i].o1));
      chk($sformatf("out3@%0d", tbl[i].k), 32'(o3_act), 32'(tbl[i].o3));
    end

    // Asynchronous reset in mid-line at h=300.
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_x", 32'(x1), 32'd0);
    chk("mid_rst_y", 32'(y1), 32'd0);
    chk("mid_rst_out1", 32'(o1_act), 32'(blk));
    chk("mid_rst_out3", 32'(o3_act), 32'(blk));
    chk("mid_rst_fs", 32'(fs1), 32'd0);
    @(posedge clk);
    #2 reset = 1'b0;
    ticks = 0;
    step_to(1);
    chk("post_rst_x1", 32'(x1), 32'd1);
    chk("post_rst_out1_t1", 32'(o1_act), 32'(blk));
    step_to(2);
    chk("post_rst_out1_t2", 32'(o1_act), 32'(o(1, 1, 1, 24'h0000A5)));
    chk("post_rst_out3_t2", 32'(o3_act), 32'(blk));
    step_to(4);
    chk("post_rst_out3_t4", 32'(o3_act), 32'(o(1, 1, 1, 24'h0000A5)));

`ifdef MIDWAY_SCAN_TEST_PATTERN_EN
    pattern_sel = 1'b1;
    step_to(132);
    chk("bar1_blue", 32'(o1_act), 32'(o(1, 1, 1, 24'h0000FF)));
    step_to(302);
    chk("bar2_green", 32'(o1_act), 32'(o(1, 1, 1, 24'h00FF00)));
    step_to(522);
    chk("bar4_red", 32'(o1_act), 32'(o(1, 1, 1, 24'hFF0000)));
    step_to(642);
    chk("bar_blank", 32'(o1_act), 32'(blk));
    pattern_sel = 1'b0;
`endif

    // pix_ce continuously high.
    #1 reset = 1'b1;
    @(negedge clk);
    window(1664, 1'b0);
    chk("cont_x_track", 32'(w_x_bad), 32'd0);
    chk("cont_hs_low", 32'(w_hs_low), 32'd192);
    chk("cont_blank_hi", 32'(w_bl), 32'd1343);
    chk("cont_hs_fall", 32'(w_hs_fall), 32'd658);
    chk("cont_s_vs_low", 32'(w_svs), 32'd256);
    chk("cont_s_hs_low", 32'(w_shs), 32'd312);
    chk("cont_s_blank_hi", 32'(w_sbl), 32'd384);
    chk("cont_s_line", 32'(w_shs_gap), 32'd16);
    chk("cont_fs_cnt", 32'(w_fs_cnt), 32'd8);
    chk("cont_fs_first", 32'(w_fs_first), 32'd207);
    chk("cont_fs_gap", 32'(w_fs_gap), 32'd208);
    chk("cont_fs_wide", 32'(w_fs_wide), 32'd0);

    // pix_ce high every other clock.
    #1 reset = 1'b1;
    @(negedge clk);
    window(1664, 1'b1);
    chk("alt_x_hold", 32'(w_x_bad), 32'd0);
    chk("alt_hs_low", 32'(w_hs_low), 32'd192);
    chk("alt_blank_hi", 32'(w_bl), 32'd1342);
    chk("alt_hs_fall", 32'(w_hs_fall), 32'd1315);
    chk("alt_s_line", 32'(w_shs_gap), 32'd32);
    chk("alt_fs_cnt", 32'(w_fs_cnt), 32'd4);
    chk("alt_fs_first", 32'(w_fs_first), 32'd414);
    chk("alt_fs_gap", 32'(w_fs_gap), 32'd416);
    chk("alt_fs_wide", 32'(w_fs_wide), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/midway_vga_scan_timing.md
Name: midway_vga_scan_timing

Overview:
- Upstream and downstream neighbour of the Midway 8080 memory adapter; generates 640x480@60 raster timing.
- Drives the 10-bit x / 9-bit y scan addresses into the adapter and pixel buffer path.
- Takes the adapter's 24-bit RGB back after a fixed memory-read latency and emits sync-aligned VGA outputs.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch
- H_SYNC, 96, hsync width
- H_BP, 48, horizontal back porch
- V_ACTIVE, 480, visible lines
- V_FP, 10, vertical front porch
- V_SYNC, 2, vsync width
- V_BP, 33, vertical back porch
- PIPE_LATENCY, 1, pix_ce ticks from address issue to valid rgb_in; legal 1..4

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- pix_ce  in  1  pixel clock enable; all state advances only when high
- vga_x_address  out  10  scan x, to adapter input_x_address
- vga_y_address  out  9  scan y, to adapter input_y_address
- rgb_in  in  24  adapter rgb_data_out, {R,G,B}
- vga_r  out  8  red
- vga_g  out  8  green
- vga_b  out  8  blue
- vga_hs_n  out  1  hsync, active low
- vga_vs_n  out  1  vsync, active low
- vga_blank_n  out  1  high during visible pixel
- frame_start  out  1  one-clk pulse at frame wrap

Behaviour:
- Totals: H_TOTAL = 800 = sum of H parameters; V_TOTAL = 525 = sum of V parameters.
- h_count: 10-bit register, range 0..H_TOTAL-1. On pix_ce it increments. At H_TOTAL-1 it wraps to 0 and v_count increments.
- v_count: 10-bit register, range 0..V_TOTAL-1; wraps to 0 after V_TOTAL-1.
- pix_ce low: counters, delay line and outputs all hold.
- Addresses are combinational from the counters:
  - vga_x_address = h_count when h_count < H_ACTIVE, else 0.
  - vga_y_address = v_count[8:0] when v_count < V_ACTIVE, else 0.
- Raw timing signals:
  - active = (h_count < H_ACTIVE) && (v_count < V_ACTIVE)
  - hs_raw low for h_count in [656, 752)
  - vs_raw low for v_count in [490, 492)
- Delay line: {active, hs_raw, vs_raw} pass through PIPE_LATENCY stages, each shifting on pix_ce. The stage output aligns with the rgb_in value for the same address.
- Output register, updated on pix_ce:
  - vga_r/g/b <= delayed active ? rgb_in fields : 0
  - vga_hs_n, vga_vs_n, vga_blank_n <= delayed values
- Total latency: address to pin = PIPE_LATENCY + 1 pix_ce ticks.
- frame_start: high for exactly one clk, on the pix_ce cycle where counters step from (H_TOTAL-1, V_TOTAL-1) to (0, 0); low otherwise.
- Reset values:
  - h_count = 0, v_count = 0
  - delay stages = {inactive, hs high, vs high}
  - vga_r/g/b = 0, vga_hs_n = 1, vga_vs_n = 1, vga_blank_n = 0, frame_start = 0
- Reset mid-frame: asynchronous clear to the values above. The next pix_ce after deassert scans (0,0). The first PIPE_LATENCY+1 ticks output blank, no sync.
- pix_ce continuously high is legal; all behaviour is identical, only the timebase changes.
- No combinational path from rgb_in to any output.

Optional Feature:
- Macro: MIDWAY_SCAN_TEST_PATTERN_EN.
- When defined:
  - Adds input pattern_sel (1 bit).
  - bar = vga_x_address[9:7] is carried through the delay line alongside active.
  - If pattern_sel=1, the output stage substitutes colour-bar RGB for rgb_in: bit2 -> R=FF, bit1 -> G=FF, bit0 -> B=FF, each else 00. Blanking rules are unchanged.
- When undefined: port absent; rgb_in always used; no extra delay bits.

Test Plan:
- Reset -> hs_n=1, vs_n=1, blank_n=0, rgb=0, x=0, y=0, frame_start=0. Assert reset at h=300, v=200 -> same values immediately, before any clk edge.
- pix_ce=1 every clk, PIPE_LATENCY=1 -> hs_n low for exactly 96 ticks per 800-tick line, falling PIPE_LATENCY+1 ticks after h_count=656. blank_n high for 640 ticks per line.
- Full frame -> vs_n low for 2 lines (1600 ticks). frame_start pulses every 420000 ticks and is single-cycle.
- Memory model returns rgb_in = {x[7:0], y[7:0], 8'hA5} after PIPE_LATENCY ticks, PIPE_LATENCY=1 and 3 -> pixel at x=5, y=7 appears as 05/07/A5 aligned with blank_n high. Blanking pixels output 000000 regardless of rgb_in.
- pix_ce high every other clk -> line period 1600 clk. Outputs and counters hold on pix_ce=0 cycles. frame_start is still one clk wide.
- MIDWAY_SCAN_TEST_PATTERN_EN, pattern_sel=1 -> x=0..127 black, x=128..255 blue (0000FF), x=512..639 red+green? No: bar index 4 -> FF0000. Blanking pixels stay 0.
